insn_encoder: RTL and testbench
===============================

// Module: insn_encoder
// PURPOSE
//  Sequential RV32I instruction encoder: packs decoded fields (format, opcode, funct3, funct7[30], regs, imm)
//  into 32-bit words and streams them into instruction memory at consecutive word addresses. It is the inverse
//  of the control-unit decode path; it is used by the bench/boot loader to build programs in IMEM.
// PARAMETERS
//  ADDR_W   10           IMEM word-address width
//  DEPTH    1<<ADDR_W    words available from BASE before overflow
//  BASE     '0           first word address written after i_start
// PORTS
//  i_clk         in   1       clock, rising edge
//  i_reset       in   1       asynchronous, active-low reset
//  i_start       in   1       pulse: arm encoder, address/count := BASE/0, clear o_err
//  i_vld         in   1       field bundle valid
//  o_rdy         out  1       encoder accepts bundle (transfer = i_vld & o_rdy)
//  i_fmt         in   3       insn_fmt_e: R,I,S,B,U,J
//  i_opcode      in   7       opcode, bits [6:0]
//  i_funct3      in   3       bits [14:12]
//  i_funct7_5    in   1       bit 30 (R-type; I-type shifts only)
//  i_rd,i_rs1,i_rs2 in 5 each register indices
//  i_imm         in   32      signed immediate; U: full value (bits 31:12 used)
//  i_last        in   1       bundle is final instruction of program
//  o_imem_addr   out  ADDR_W  write word address
//  o_imem_wdata  out  32      encoded instruction
//  o_imem_wren   out  1       one-cycle write strobe
//  o_count       out  ADDR_W+1 words written since i_start
//  o_done        out  1       one-cycle pulse after final write
//  o_err         out  2       sticky: [0] illegal field, [1] overflow
// BEHAVIOUR
//  Reset: state IDLE, o_rdy=0, o_imem_wren=0, o_imem_addr=BASE, o_imem_wdata=0, o_count=0, o_done=0, o_err=0.
//  FSM IDLE -(i_start)-> RUN -(accepted & i_last)-> FLUSH -> DONE -> IDLE. i_start in any state -> RUN, rearms.
//  o_rdy=1 only in RUN. Accepted bundle is encoded combinationally, registered; o_imem_wren asserts the next
//  cycle with addr = BASE+o_count, then o_count++. Latency acceptance->write = 1 cycle; throughput 1/cycle.
//  FLUSH drains the last write; DONE asserts o_done for one cycle (o_imem_wren already low).
//  Encoding: R {f7_5,5'b0 pre,rs2,rs1,f3,rd,op} (bit30=f7_5, others 0); I {imm[11:0],rs1,f3,rd,op}, and when
//  opcode=0010011 & f3 in {001,101}: {1'b0,f7_5,5'b0,imm[4:0]} in [31:20]; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//  B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],
//  imm[19:12],rd,op}. Unused fields ignored. i_fmt outside R..J: bundle accepted, not written, o_err[0]=1.
//  Overflow: bundle accepted when o_count==DEPTH -> not written, o_count holds, o_err[1]=1; stream continues.
//  Address does not wrap within a program; BASE+DEPTH-1 is last legal address.
//  i_vld without o_rdy is ignored (not queued). Reset mid-program aborts: pending write dropped, all to reset values.
//  Simultaneous i_start with an accepted bundle: i_start wins, bundle discarded.
// CONFIGURATION
//  INSN_ENC_CHECK_EN defined: range checks; I/S imm not a sign-extended 12-bit value, B imm not 13-bit or
//  bit0!=0, J imm not 21-bit or bit0!=0, U imm[11:0]!=0, shift imm[11:5] nonzero -> bundle not written,
//  o_err[0]=1. Undefined: fields truncated silently; only bad i_fmt sets o_err[0].
// STRUCTURE
//  Shared package rv32i_pkg: insn_fmt_e enum, opcode constants (OP_LOAD 0000011, OP_IMM 0010011, OP_AUIPC,
//  OP_STORE, OP_REG, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL), enc_state_e. One combinational sub-module
//  insn_pack (fields -> word + illegal flag); FSM, counters and output register live in insn_encoder.
// TESTING
//  start; addi x1,x0,5 (I) -> write addr BASE, data 0x00500093, o_count=1, one cycle after acceptance.
//  back-to-back R: add x3,x1,x2 then sub x3,x1,x2 -> 0x002081B3, 0x402081B3 on consecutive cycles/addresses.
//  S/B/J/U: sw x2,8(x1) 0x0020A423; beq x1,x2,+8 0x00208463; jal x1,+16 0x010000EF; lui x5,0x12345000 0x123452B7.
//  srai x1,x1,3 with i_last -> 0x4030D093 written, o_done pulses 2 cycles later, FSM IDLE, o_rdy=0.
//  DEPTH=4: 5 bundles -> 4 writes, o_err=2'b10, o_count=4; i_start clears o_err; reset mid-stream -> no wren.
//  CHECK_EN: beq imm=+7 -> no write, o_err[0]=1; without macro same input writes 0x00208363 (bit0 dropped).

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the instruction encoder: formats, opcodes, FSM states.
// Range-check helpers are used only when INSN_ENC_CHECK_EN is defined.
package rv32i_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } insn_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  // True when v is the sign extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic is_imm_shift(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));
  endfunction

endpackage

// File: rtl/insn_encoder_if.sv
// Field-bundle handshake and IMEM write bus between a program builder and insn_encoder.
interface insn_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              i_vld;
  logic              o_rdy;
  logic [2:0]        i_fmt;
  logic [6:0]        i_opcode;
  logic [2:0]        i_funct3;
  logic              i_funct7_5;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [31:0]       i_imm;
  logic              i_last;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [31:0]       o_imem_wdata;
  logic              o_imem_wren;

  modport master (
    output i_vld, i_fmt, i_opcode, i_funct3, i_funct7_5, i_rd, i_rs1, i_rs2, i_imm, i_last,
    input  o_rdy, o_imem_addr, o_imem_wdata, o_imem_wren
  );

  modport slave (
    input  i_vld, i_fmt, i_opcode, i_funct3, i_funct7_5, i_rd, i_rs1, i_rs2, i_imm, i_last,
    output o_rdy, o_imem_addr, o_imem_wdata, o_imem_wren
  );
endinterface

// File: rtl/insn_encoder_pack.sv
// insn_pack: combinational RV32I field packer (fields -> 32-bit word + illegal flag).
// Macro INSN_ENC_CHECK_EN adds immediate range checks to the illegal flag.
module insn_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic fmt_bad;
  logic shift;

  assign shift = is_imm_shift(opcode, funct3);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    word    = '0;
    fmt_bad = 1'b0;
    case (insn_fmt_e'(fmt))
      FMT_R: word = {1'b0, funct7_5, 5'b0, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (shift) word = {1'b0, funct7_5, 5'b0, imm[4:0], rs1, funct3, rd, opcode};
        else       word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef INSN_ENC_CHECK_EN
  logic range_bad;

  always_comb begin
    range_bad = 1'b0;
    case (insn_fmt_e'(fmt))
      FMT_I:   range_bad = !fits_signed(imm, 12) || (shift && (imm[11:5] != 7'd0));
      FMT_S:   range_bad = !fits_signed(imm, 12);
      FMT_B:   range_bad = !fits_signed(imm, 13) || imm[0];
      FMT_J:   range_bad = !fits_signed(imm, 21) || imm[0];
      FMT_U:   range_bad = (imm[11:0] != 12'd0);
      default: range_bad = 1'b0;
    endcase
  end

  assign illegal = fmt_bad | range_bad;
`else
  assign illegal = fmt_bad;
`endif

endmodule

// File: rtl/insn_encoder.sv
// insn_encoder: accepts decoded RV32I field bundles, packs them and streams words into IMEM
// from BASE upward. Range checking is controlled by INSN_ENC_CHECK_EN (see insn_pack).
module insn_encoder
  import rv32i_pkg::*;
#(
  parameter int                ADDR_W = 10,
  parameter int                DEPTH  = 1 << ADDR_W,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  insn_encoder_if.slave   bus,
  output logic [ADDR_W:0] o_count,
  output logic            o_done,
  output logic [1:0]      o_err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);

  enc_state_e        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic [1:0]        err_q, err_d;

  logic [31:0] word;
  logic        illegal;
  logic        accept;

  insn_pack u_pack (
    .fmt      (bus.i_fmt),
    .opcode   (bus.i_opcode),
    .funct3   (bus.i_funct3),
    .funct7_5 (bus.i_funct7_5),
    .rd       (bus.i_rd),
    .rs1      (bus.i_rs1),
    .rs2      (bus.i_rs2),
    .imm      (bus.i_imm),
    .word     (word),
    .illegal  (illegal)
  );

  assign accept = bus.i_vld && (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    err_d   = err_q;
    // A start pulse rearms the program and discards any bundle offered in the same cycle.
    if (i_start) begin
      state_d = ST_RUN;
      count_d = '0;
      addr_d  = BASE;
      err_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (illegal) begin
              err_d[0] = 1'b1;
            end else if (count_q == DEPTH_C) begin
              err_d[1] = 1'b1;
            end else begin
              wren_d  = 1'b1;
              addr_d  = BASE + count_q[ADDR_W-1:0];
              wdata_d = word;
              count_d = count_q + CW'(1);
            end
            if (bus.i_last) state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      addr_q  <= BASE;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_rdy        = (state_q == ST_RUN);
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_wdata = wdata_q;
  assign bus.o_imem_wren  = wren_q;
  assign o_count          = count_q;
  assign o_done           = (state_q == ST_DONE);
  assign o_err            = err_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed bench for insn_encoder with a write scoreboard (DEPTH=4, BASE=16).
module tb_insn_encoder;
  import rv32i_pkg::*;

  localparam int                ADDR_W = 10;
  localparam int                DEPTH  = 4;
  localparam logic [ADDR_W-1:0] BASE   = 10'd16;

  logic            i_clk   = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_start = 1'b0;
  logic [ADDR_W:0] o_count;
  logic            o_done;
  logic [1:0]      o_err;

  insn_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  insn_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .bus     (bus.slave),
    .o_count (o_count),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [ADDR_W:0]   count;
  } exp_t;

  exp_t sb[$];
  int   exp_count = 0;
  int   checks    = 0;
  int   failures  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  // Offers one bundle for a single cycle; expected writes go to the scoreboard.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic f75, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp_word, input bit expect_write);
    exp_t e;
    bus.i_fmt      = fmt;
    bus.i_opcode   = op;
    bus.i_funct3   = f3;
    bus.i_funct7_5 = f75;
    bus.i_rd       = rd;
    bus.i_rs1      = rs1;
    bus.i_rs2      = rs2;
    bus.i_imm      = imm;
    bus.i_last     = last;
    bus.i_vld      = 1'b1;
    if (expect_write) begin
      e.addr  = BASE + ADDR_W'(exp_count);
      e.data  = exp_word;
      e.count = (ADDR_W+1)'(exp_count + 1);
      sb.push_back(e);
      exp_count++;
    end
    tick();
    bus.i_vld  = 1'b0;
    bus.i_last = 1'b0;
  endtask

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge i_clk) begin
    exp_t e;
    if (bus.o_imem_wren === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wren", 32'(bus.o_imem_wren), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr",  32'(bus.o_imem_addr), 32'(e.addr));
        check("wr_data",  bus.o_imem_wdata,     e.data);
        check("wr_count", 32'(o_count),         32'(e.count));
      end
    end
  end

  initial begin
    bus.i_vld = 1'b0; bus.i_fmt = '0; bus.i_opcode = '0; bus.i_funct3 = '0;
    bus.i_funct7_5 = 1'b0; bus.i_rd = '0; bus.i_rs1 = '0; bus.i_rs2 = '0;
    bus.i_imm = '0; bus.i_last = 1'b0;

    #2 i_reset = 1'b0;
    tick(); tick(); mid();
    check("rst_rdy",   32'(bus.o_rdy),       32'd0);
    check("rst_wren",  32'(bus.o_imem_wren), 32'd0);
    check("rst_addr",  32'(bus.o_imem_addr), 32'(BASE));
    check("rst_wdata", bus.o_imem_wdata,     32'd0);
    check("rst_count", 32'(o_count),         32'd0);
    check("rst_done",  32'(o_done),          32'd0);
    check("rst_err",   32'(o_err),           32'd0);
    i_reset = 1'b1;
    tick();

    // Program 1: I, back-to-back R, S, then one overflow bundle.
    i_start = 1'b1; tick(); i_start = 1'b0; exp_count = 0;
    mid(); check("run_rdy", 32'(bus.o_rdy), 32'd1);
    send(FMT_I, OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h00500093, 1'b1);
    mid(); check("addi_latency", 32'(bus.o_imem_wren), 32'd1);
    send(FMT_R, OP_REG, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3, 1'b1);
    mid(); check("add_wren", 32'(bus.o_imem_wren), 32'd1);
    send(FMT_R, OP_REG, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h402081B3, 1'b1);
    mid(); check("sub_wren", 32'(bus.o_imem_wren), 32'd1);
    send(FMT_S, OP_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020A423, 1'b1);
    mid(); check("full_count", 32'(o_count), 32'd4);
    send(FMT_B, OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0, 1'b0);
    mid();
    check("ovf_wren",  32'(bus.o_imem_wren), 32'd0);
    check("ovf_err",   32'(o_err),           32'd2);
    check("ovf_count", 32'(o_count),         32'd4);

    // Program 2: restart clears errors; B, J, U, then shift with i_last.
    i_start = 1'b1; tick(); i_start = 1'b0; exp_count = 0;
    mid();
    check("restart_err",   32'(o_err),           32'd0);
    check("restart_count", 32'(o_count),         32'd0);
    check("restart_addr",  32'(bus.o_imem_addr), 32'(BASE));
    send(FMT_B, OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h00208463, 1'b1);
    send(FMT_J, OP_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 32'h010000EF, 1'b1);
    send(FMT_U, OP_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123452B7, 1'b1);
    send(FMT_I, OP_IMM, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 32'd3, 1'b1, 32'h4030D093, 1'b1);
    mid();
    check("last_wren",  32'(bus.o_imem_wren), 32'd1);
    check("flush_done", 32'(o_done),          32'd0);
    check("flush_rdy",  32'(bus.o_rdy),       32'd0);
    tick(); mid();
    check("done_pulse", 32'(o_done),          32'd1);
    check("done_wren",  32'(bus.o_imem_wren), 32'd0);
    tick(); mid();
    check("done_end",   32'(o_done),      32'd0);
    check("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("idle_rdy",   32'(bus.o_rdy),   32'd0);

    // Bundle offered while idle is ignored.
    send(FMT_I, OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 1'b0);
    mid(); check("idle_ignore_count", 32'(o_count), 32'd4);

    // Illegal format: accepted, not written, err[0].
    i_start = 1'b1; tick(); i_start = 1'b0; exp_count = 0;
    send(3'd6, OP_REG, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0, 1'b0);
    mid();
    check("badfmt_err",   32'(o_err),   32'd1);
    check("badfmt_count", 32'(o_count), 32'd0);

    // Misaligned branch offset.
    i_start = 1'b1; tick(); i_start = 1'b0; exp_count = 0;
`ifdef INSN_ENC_CHECK_EN
    send(FMT_B, OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 32'h0, 1'b0);
    mid();
    check("beq7_err",   32'(o_err),   32'd1);
    check("beq7_count", 32'(o_count), 32'd0);
`else
    send(FMT_B, OP_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 32'h00208363, 1'b1);
    mid();
    check("beq7_err",   32'(o_err),   32'd0);
    check("beq7_count", 32'(o_count), 32'd1);
`endif

    // i_start together with a bundle: the bundle is discarded.
    i_start = 1'b1;
    send(FMT_I, OP_IMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0, 1'b0);
    i_start = 1'b0; exp_count = 0;
    mid();
    check("collide_wren",  32'(bus.o_imem_wren), 32'd0);
    check("collide_count", 32'(o_count),         32'd0);

    // Reset right after acceptance drops the pending write.
    bus.i_fmt = FMT_I; bus.i_opcode = OP_IMM; bus.i_funct3 = 3'b000;
    bus.i_rd = 5'd1; bus.i_rs1 = 5'd0; bus.i_imm = 32'd5; bus.i_vld = 1'b1;
    tick();
    i_reset = 1'b0; bus.i_vld = 1'b0;
    mid();
    check("abort_wren",  32'(bus.o_imem_wren), 32'd0);
    check("abort_count", 32'(o_count),         32'd0);
    check("abort_addr",  32'(bus.o_imem_addr), 32'(BASE));
    check("abort_wdata", bus.o_imem_wdata,     32'd0);
    check("abort_rdy",   32'(bus.o_rdy),       32'd0);
    i_reset = 1'b1;
    repeat (3) tick();
    mid();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
